serial_ifft_coral: RTL and testbench



---
 rtl/serial_ifft_coral_pkg.sv | 25 ++
 rtl/serial_ifft_coral_cmac_node.sv | 75 +++++++
 rtl/serial_ifft_coral.sv | 76 +++++++
 tb/tb_serial_ifft_coral.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_ifft_coral_pkg.sv
// rtl/serial_ifft_coral_pkg.sv - shared widths, counter-width helper and stage-1 payload for the serial IFFT core
package ifft_pkg;

    localparam int DEF_W_WIDTH = 16;
    localparam int DEF_X_WIDTH = 16;
    localparam int DEF_S_WIDTH = 32;

    // Products are carried sign-extended to this width so one payload type
    // serves every W_WIDTH/X_WIDTH/S_WIDTH combination up to 64 bits.
    localparam int PROD_W = 64;

    // Bin counter width; never below one bit so the counter always exists.
    function automatic int cnt_width(input int frame_length);
        return (frame_length <= 2) ? 1 : $clog2(frame_length);
    endfunction

    typedef struct packed {
        logic signed [PROD_W-1:0] p_re;
        logic signed [PROD_W-1:0] p_im;
        logic                     first;
        logic                     last;
        logic                     valid;
    } s1_payload_t;

endpackage

// File: rtl/serial_ifft_coral_cmac_node.sv
// rtl/serial_ifft_coral_cmac_node.sv - registered real-part complex multiply followed by frame accumulator
module cmac_node
    import ifft_pkg::*;
#(
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int X_WIDTH = DEF_X_WIDTH,
    parameter int S_WIDTH = DEF_S_WIDTH,
    parameter int SHIFT   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic                      first_i,
    input  logic                      last_i,
    input  logic signed [X_WIDTH-1:0] x_re,
    input  logic signed [X_WIDTH-1:0] x_im,
    input  logic signed [W_WIDTH-1:0] w_re,
    input  logic signed [W_WIDTH-1:0] w_im,
    output logic signed [S_WIDTH-1:0] sample,
    output logic                      valid_o
);

    s1_payload_t               s1_d, s1_q;
    logic signed [S_WIDTH-1:0] acc_d, acc_q;
    logic signed [S_WIDTH-1:0] sample_d, sample_q;
    logic                      valid_o_d, valid_o_q;
    logic signed [S_WIDTH-1:0] p_re_s, p_im_s, base, sum;

    // Stage 1: full-precision products plus the tags that travel with them
    always_comb begin
        s1_d       = '0;
        s1_d.p_re  = PROD_W'(x_re) * PROD_W'(w_re);
        s1_d.p_im  = PROD_W'(x_im) * PROD_W'(w_im);
        s1_d.first = first_i;
        s1_d.last  = last_i;
        s1_d.valid = valid_i;
    end

    // Stage 2: accumulate re - im; the first tag restarts the sum, last publishes it
    always_comb begin
        p_re_s    = s1_q.p_re[S_WIDTH-1:0];
        p_im_s    = s1_q.p_im[S_WIDTH-1:0];
        base      = s1_q.first ? '0 : acc_q;
        sum       = base + p_re_s - p_im_s;
        acc_d     = acc_q;
        sample_d  = sample_q;
        valid_o_d = 1'b0;
        if (s1_q.valid) begin
            acc_d = sum;
            if (s1_q.last) begin
                sample_d  = sum >>> SHIFT;
                valid_o_d = 1'b1;
            end
        end
    end

    // Pipeline and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            valid_o_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            valid_o_q <= valid_o_d;
        end
    end

    assign sample  = sample_q;
    assign valid_o = valid_o_q;

endmodule

// File: rtl/serial_ifft_coral.sv
// rtl/serial_ifft_coral.sv - serial inverse-DFT sample synthesis: bin counter, sync handling, twiddle select
module serial_ifft_coral
    import ifft_pkg::*;
#(
    parameter int W_WIDTH      = DEF_W_WIDTH,
    parameter int X_WIDTH      = DEF_X_WIDTH,
    parameter int S_WIDTH      = DEF_S_WIDTH,
    parameter int FRAME_LENGTH = 3,
    parameter int SHIFT        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [W_WIDTH-1:0] w_re [FRAME_LENGTH],
    input  logic signed [W_WIDTH-1:0] w_im [FRAME_LENGTH],
    input  logic                      valid_i,
    input  logic                      sync_i,
    input  logic signed [X_WIDTH-1:0] x_re,
    input  logic signed [X_WIDTH-1:0] x_im,
    output logic signed [S_WIDTH-1:0] sample,
    output logic                      valid_o,
    output logic                      frame_err_o
);

    localparam int              CW     = cnt_width(FRAME_LENGTH);
    localparam logic [CW-1:0]   K_LAST = CW'(FRAME_LENGTH - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic [CW-1:0] k_eff;
    logic          frame_err_d, frame_err_q;
    logic          first, last;

    // A synced beat is forced to bin 0; a sync landing mid-frame flags an abort
    always_comb begin
        k_eff       = (valid_i && sync_i) ? '0 : cnt_q;
        first       = (k_eff == '0);
        last        = (k_eff == K_LAST);
        cnt_d       = cnt_q;
        if (valid_i) begin
            cnt_d = last ? '0 : k_eff + 1'b1;
        end
        frame_err_d = valid_i && sync_i && (cnt_q != '0);
    end

    // Bin counter and abort pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    cmac_node #(
        .W_WIDTH (W_WIDTH),
        .X_WIDTH (X_WIDTH),
        .S_WIDTH (S_WIDTH),
        .SHIFT   (SHIFT)
    ) u_node (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .first_i (first),
        .last_i  (last),
        .x_re    (x_re),
        .x_im    (x_im),
        .w_re    (w_re[k_eff]),
        .w_im    (w_im[k_eff]),
        .sample  (sample),
        .valid_o (valid_o)
    );

    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_serial_ifft_coral.sv
// tb/tb_serial_ifft_coral.sv - directed self-checking bench for serial_ifft_coral
module tb_serial_ifft_coral;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] w_re [3];
    logic signed [15:0] w_im [3];
    logic               valid_i, sync_i;
    logic signed [15:0] x_re, x_im;
    logic signed [31:0] sample, sample_s1;
    logic               valid_o, valid_o_s1;
    logic               frame_err_o, frame_err_s1;

    int n_chk = 0;
    int n_err = 0;
    int vo_cnt = 0;
    int fe_cnt = 0;
    int vo0, fe0;
    logic signed [31:0] samples [$];

    always #5 clk = ~clk;

    serial_ifft_coral #(
        .W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(3), .SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .w_re(w_re), .w_im(w_im),
        .valid_i(valid_i), .sync_i(sync_i), .x_re(x_re), .x_im(x_im),
        .sample(sample), .valid_o(valid_o), .frame_err_o(frame_err_o)
    );

    serial_ifft_coral #(
        .W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(3), .SHIFT(1)
    ) dut_s1 (
        .clk(clk), .rst(rst), .w_re(w_re), .w_im(w_im),
        .valid_i(valid_i), .sync_i(sync_i), .x_re(x_re), .x_im(x_im),
        .sample(sample_s1), .valid_o(valid_o_s1), .frame_err_o(frame_err_s1)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_o) begin
            vo_cnt++;
            samples.push_back(sample);
        end
        if (frame_err_o) fe_cnt++;
    end

    task automatic set_w(input int r0, input int r1, input int r2,
                         input int i0, input int i1, input int i2);
        w_re[0] = 16'(r0); w_re[1] = 16'(r1); w_re[2] = 16'(r2);
        w_im[0] = 16'(i0); w_im[1] = 16'(i1); w_im[2] = 16'(i2);
    endtask

    task automatic send_bin(input logic s, input int xr, input int xi);
        @(negedge clk);
        valid_i = 1'b1;
        sync_i  = s;
        x_re    = 16'(xr);
        x_im    = 16'(xi);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
            sync_i  = 1'b0;
        end
    endtask

    task automatic wait_vo(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            sync_i  = 1'b0;
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; sync_i = 1'b0; x_re = '0; x_im = '0;
        set_w(1, 1, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_sample", sample, 0);
        check_eq("rst_valid_o", valid_o, 0);
        check_eq("rst_frame_err", frame_err_o, 0);
        check_eq("rst_sample_s1", sample_s1, 0);
        rst = 1'b0;
        idle(2);

        // Plain sum and exact two-cycle latency
        send_bin(1, 1, 0);
        send_bin(0, 2, 0);
        send_bin(0, 3, 0);
        idle(1);
        check_eq("sum_lat1_valid_o", valid_o, 0);
        @(negedge clk);
        check_eq("sum_lat2_valid_o", valid_o, 1);
        check_eq("sum_sample", sample, 6);
        @(negedge clk);
        check_eq("sum_pulse_end", valid_o, 0);
        check_eq("sum_hold", sample, 6);
        idle(2);

        // Imaginary term subtracts
        set_w(1, 0, 0, 0, 1, 0);
        send_bin(1, 4, 0);
        send_bin(0, 0, 5);
        send_bin(0, 7, 7);
        wait_vo("imag");
        check_eq("imag_sample", sample, -1);
        idle(2);

        // Sign and arithmetic shift
        set_w(-2, -2, -2, 0, 0, 0);
        send_bin(1, 3, 0);
        send_bin(0, 3, 0);
        send_bin(0, 3, 0);
        wait_vo("scale");
        check_eq("scale_sample_sh0", sample, -18);
        check_eq("scale_sample_sh1", sample_s1, -9);
        idle(2);

        // Gaps inside frame A, frame B immediately after without sync
        set_w(1, 2, 3, 1, 1, 1);
        samples.delete();
        vo0 = vo_cnt; fe0 = fe_cnt;
        send_bin(1, 5, 1);
        idle(int'($urandom_range(0, 2)));
        send_bin(0, 0, 0);
        idle(int'($urandom_range(1, 3)));
        send_bin(0, 1, -2);
        send_bin(0, 2, 3);
        send_bin(0, 4, 0);
        send_bin(0, -1, 1);
        idle(6);
        check_eq("b2b_pulses", vo_cnt - vo0, 2);
        check_eq("b2b_count", samples.size(), 2);
        check_eq("b2b_frame_a", (samples.size() > 0) ? samples[0] : 32'sd12345, 9);
        check_eq("b2b_frame_b", (samples.size() > 1) ? samples[1] : 32'sd12345, 3);
        check_eq("b2b_no_err", fe_cnt - fe0, 0);

        // Sync mid-frame aborts the partial frame
        set_w(1, 1, 1, 0, 0, 0);
        vo0 = vo_cnt; fe0 = fe_cnt;
        send_bin(1, 5, 0);
        send_bin(0, 6, 0);
        send_bin(1, 1, 0);
        send_bin(0, 1, 0);
        check_eq("abort_err_pulse", frame_err_o, 1);
        send_bin(0, 1, 0);
        check_eq("abort_err_once", frame_err_o, 0);
        wait_vo("abort");
        check_eq("abort_sample", sample, 3);
        idle(3);
        check_eq("abort_err_cnt", fe_cnt - fe0, 1);
        check_eq("abort_vo_cnt", vo_cnt - vo0, 1);

        // Reset mid-frame clears everything and emits nothing
        vo0 = vo_cnt; fe0 = fe_cnt;
        send_bin(1, 9, 9);
        send_bin(0, 9, 9);
        @(negedge clk);
        valid_i = 1'b0; sync_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_sample", sample, 0);
        check_eq("midrst_valid_o", valid_o, 0);
        check_eq("midrst_frame_err", frame_err_o, 0);
        rst = 1'b0;
        idle(4);
        check_eq("midrst_no_vo", vo_cnt - vo0, 0);
        check_eq("midrst_no_err", fe_cnt - fe0, 0);
        send_bin(0, 1, 0);
        send_bin(0, 2, 0);
        send_bin(0, 3, 0);
        wait_vo("postrst");
        check_eq("postrst_sample", sample, 6);
        idle(3);
        check_eq("postrst_no_err", fe_cnt - fe0, 0);

        // Two's complement wrap with full-scale operands
        set_w(-32768, -32768, -32768, -32768, -32768, -32768);
        send_bin(1, -32768, 32767);
        send_bin(0, -32768, 32767);
        send_bin(0, -32768, 32767);
        wait_vo("ovf_pos");
        check_eq("ovf_pos_sh0", sample, 2147385344);
        check_eq("ovf_pos_sh1", sample_s1, 1073692672);
        send_bin(1, 32767, -32768);
        send_bin(0, 32767, -32768);
        send_bin(0, 32767, -32768);
        wait_vo("ovf_neg");
        check_eq("ovf_neg_sh0", sample, -2147385344);
        check_eq("ovf_neg_sh1", sample_s1, -1073692672);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
